// File: rtl/rot_arbiter_pkg.sv
// Shared constants, state encoding and width helper for the
// round-robin rotate-right arbiter.
package rot_arbiter_pkg;

    localparam int DW  = 8;
    localparam int AMW = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROT  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int idw_calc(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/rot8_right.sv
// Combinational 8-bit rotate-right by 0..7 positions.
module rot8_right
    import rot_arbiter_pkg::*;
(
    input  logic [DW-1:0]  a,
    input  logic [AMW-1:0] amt,
    output logic [DW-1:0]  y
);

    always_comb begin
        y = a;
        case (amt)
            3'd0: y = a;
            3'd1: y = {a[0],   a[7:1]};
            3'd2: y = {a[1:0], a[7:2]};
            3'd3: y = {a[2:0], a[7:3]};
            3'd4: y = {a[3:0], a[7:4]};
            3'd5: y = {a[4:0], a[7:5]};
            3'd6: y = {a[5:0], a[7:6]};
            3'd7: y = {a[6:0], a[7]};
            default: y = a;
        endcase
    end

endmodule

// File: rtl/rot_arbiter.sv
// Round-robin arbiter sharing one rotate-right datapath among NREQ
// requesters; three-state sequencer with registered result and done pulse.
module rot_arbiter
    import rot_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = idw_calc(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [DW*NREQ-1:0]    a_in,
    input  logic [AMW*NREQ-1:0]   amt_in,
    output logic [NREQ-1:0]       gnt,
    output logic [DW-1:0]         y,
    output logic                  done,
    output logic [IDW-1:0]        done_id,
    output logic                  busy
);

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [DW-1:0]   a_q, a_d;
    logic [AMW-1:0]  amt_q, amt_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [NREQ-1:0] gnt_d;
    logic [DW-1:0]   y_d;
    logic            done_d;
    logic [IDW-1:0]  done_id_d;
    logic [IDW-1:0]  win;
    logic [DW-1:0]   rot_y;

    // First set request at or after ptr, wrapping modulo NREQ.
    function automatic logic [IDW-1:0] rr_pick(
        input logic [NREQ-1:0] r,
        input logic [IDW-1:0]  p
    );
        logic [IDW-1:0] w;
        logic           found;
        w     = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            int idx;
            idx = (int'(p) + i) % NREQ;
            if (!found && r[idx]) begin
                w     = IDW'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    rot8_right u_rot (
        .a   (a_q),
        .amt (amt_q),
        .y   (rot_y)
    );

    assign win  = rr_pick(req, ptr_q);
    assign busy = (state_q == ST_ROT) || (state_q == ST_DONE);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        a_d       = a_q;
        amt_d     = amt_q;
        id_d      = id_q;
        gnt_d     = gnt;
        y_d       = y;
        done_d    = 1'b0;
        done_id_d = done_id;
        case (state_q)
            ST_ROT: begin
                y_d       = rot_y;
                done_id_d = id_q;
                done_d    = 1'b1;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                gnt_d   = '0;
                ptr_d   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
                state_d = ST_IDLE;
            end
            default: begin
                // Unused encoding 2'd3 behaves as IDLE.
                if (|req) begin
                    a_d        = a_in[int'(win)*DW +: DW];
                    amt_d      = amt_in[int'(win)*AMW +: AMW];
                    id_d       = win;
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    state_d    = ST_ROT;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            a_q     <= '0;
            amt_q   <= '0;
            id_q    <= '0;
            gnt     <= '0;
            y       <= '0;
            done    <= 1'b0;
            done_id <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            a_q     <= a_d;
            amt_q   <= amt_d;
            id_q    <= id_d;
            gnt     <= gnt_d;
            y       <= y_d;
            done    <= done_d;
            done_id <= done_id_d;
        end
    end

endmodule

// File: tb/tb_rot_arbiter.sv
// Scoreboard bench for rot_arbiter: a cycle model predicts grants and
// results, directed sequences check ordering, latency and reset abort.
module tb_rot_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] a_in = '0;
    logic [3*N-1:0] amt_in = '0;
    logic [N-1:0]   gnt;
    logic [7:0]     y;
    logic           done;
    logic [1:0]     done_id;
    logic           busy;

    rot_arbiter #(.NREQ(N), .IDW(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .a_in    (a_in),
        .amt_in  (amt_in),
        .gnt     (gnt),
        .y       (y),
        .done    (done),
        .done_id (done_id),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0] id;
        logic [7:0] y;
    } exp_t;

    exp_t       exp_q[$];
    int         m_phase = 0;
    int         m_ptr = 0;
    int         m_id = 0;
    logic [3:0] m_gnt = '0;
    logic [7:0] m_y = '0;
    bit         arm = 1'b0;
    int         cyc = 0;
    int         ids[$];
    int         dcyc[$];

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_rotr(input logic [7:0] a,
                                            input logic [2:0] s);
        logic [15:0] t;
        t = {a, a} >> s;
        return t[7:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference model: pushes the expected result at the sampling edge.
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            if (m_phase == 1 && exp_q.size() > 0) void'(exp_q.pop_back());
            m_phase = 0;
            m_ptr   = 0;
            m_gnt   = '0;
            m_y     = '0;
        end else begin
            case (m_phase)
                0: begin
                    if (req != 0) begin
                        exp_t e;
                        int   w;
                        w = 0;
                        for (int i = 0; i < N; i++) begin
                            int k;
                            k = (m_ptr + i) % N;
                            if (req[k]) begin
                                w = k;
                                break;
                            end
                        end
                        e.id = 2'(w);
                        e.y  = ref_rotr(a_in[8*w +: 8], amt_in[3*w +: 3]);
                        exp_q.push_back(e);
                        m_id    = w;
                        m_gnt   = 4'(1 << w);
                        m_phase = 1;
                    end
                end
                1: begin
                    m_y     = exp_q[exp_q.size()-1].y;
                    m_phase = 2;
                end
                default: begin
                    m_gnt   = '0;
                    m_ptr   = (m_id + 1) % N;
                    m_phase = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (arm) begin
            exp_t e;
            chk("gnt", 32'(gnt), 32'(m_gnt));
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("done", 32'(done), 32'(m_phase == 2));
            chk("y_hold", 32'(y), 32'(m_y));
            chk("onehot", 32'($countones(gnt) <= 1), 32'd1);
            if (m_phase == 2) begin
                if (exp_q.size() == 0) begin
                    chk("sb_empty", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_id", 32'(done_id), 32'(e.id));
                    chk("sb_y", 32'(y), 32'(e.y));
                end
            end
            if (done === 1'b1) begin
                ids.push_back(int'(done_id));
                dcyc.push_back(cyc);
            end
        end
    end

    task automatic run_one(input int id, input logic [7:0] a,
                           input logic [2:0] amt, input logic [7:0] exp_y);
        tick();
        req              = 4'(1 << id);
        a_in[8*id +: 8]  = a;
        amt_in[3*id +: 3] = amt;
        for (int i = 0; i < 8 && done !== 1'b1; i++) @(negedge clk);
        chk("one_done", 32'(done), 32'd1);
        chk("one_y", 32'(y), 32'(exp_y));
        chk("one_id", 32'(done_id), 32'(id));
        chk("one_gnt", 32'(gnt), 32'(1 << id));
        req = '0;
        tick();
        tick();
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        req   = '0;
        tick();
        tick();
        ids.delete();
        dcyc.delete();
    endtask

    task automatic wait_ids(input int n);
        for (int i = 0; i < 80 && ids.size() < n; i++) tick();
        chk("wait_ids", 32'(ids.size() >= n), 32'd1);
    endtask

    task automatic run_held(input logic [3:0] r, input int e0, input int e1,
                            input int e2, input int e3, input int e4);
        int exp_ids[5];
        exp_ids = '{e0, e1, e2, e3, e4};
        do_reset();
        req    = r;
        a_in   = 32'h3C_81_A5_96;
        amt_in = 12'b101_010_001_011;
        reset  = 1'b0;
        wait_ids(5);
        req = '0;
        if (ids.size() >= 5) begin
            for (int i = 0; i < 5; i++) chk("seq_id", 32'(ids[i]), 32'(exp_ids[i]));
            for (int i = 1; i < 5; i++) chk("seq_gap", 32'(dcyc[i] - dcyc[i-1]), 32'd3);
        end
        repeat (4) tick();
    endtask

    initial begin
        repeat (3) tick();
        arm = 1'b1;
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_id", 32'(done_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        tick();
        reset = 1'b0;

        run_one(0, 8'h96, 3'd3, 8'hD2);
        run_one(2, 8'hA5, 3'd0, 8'hA5);
        run_one(2, 8'h01, 3'd7, 8'h02);
        run_one(2, 8'h80, 3'd1, 8'h40);

        run_held(4'b1111, 0, 1, 2, 3, 0);
        run_held(4'b0101, 0, 2, 0, 2, 0);

        tick();
        req         = 4'b0001;
        a_in[7:0]   = 8'h96;
        amt_in[2:0] = 3'd3;
        tick();
        a_in[7:0] = 8'hFF;
        req       = '0;
        for (int i = 0; i < 6 && done !== 1'b1; i++) @(negedge clk);
        chk("late_done", 32'(done), 32'd1);
        chk("late_y", 32'(y), 32'hD2);
        repeat (3) tick();

        run_one(2, 8'h3C, 3'd2, 8'h0F);
        req           = 4'b1000;
        a_in[31:24]   = 8'h55;
        amt_in[11:9]  = 3'd4;
        tick();
        reset = 1'b1;
        req   = '0;
        tick();
        @(negedge clk);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_gnt", 32'(gnt), 32'd0);
        chk("abort_y", 32'(y), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        tick();
        reset = 1'b0;
        req   = 4'b1111;
        for (int i = 0; i < 8 && done !== 1'b1; i++) @(negedge clk);
        chk("restart_done", 32'(done), 32'd1);
        chk("restart_id", 32'(done_id), 32'd0);
        req = '0;
        repeat (4) tick();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
